spi_master: RTL and testbench

Single-channel SPI initiator (mode 0: CPOL=0, CPHA=0) that drives `sck`/`ss_n`/`mosi` and samples `miso` toward an SPI target on the peripheral bus. It accepts one full-duplex transfer per request on a valid/ready command port and returns the received word on a one-cycle response strobe. It sits between the core-side peripheral glue and external SPI target devices, such as the bit-reversal test peripheral.

---
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_master.sv | 163 ++++++++++++++++
 tb/tb_spi_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Command/response port of the SPI initiator: valid/ready request in, one-cycle response strobe out.
interface spi_master_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] tx_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rx_data;

  // master = core-side requester, slave = the SPI initiator serving requests
  modport master (
    output req_valid, tx_data,
    input  req_ready, rsp_valid, rx_data
  );

  modport slave (
    input  req_valid, tx_data,
    output req_ready, rsp_valid, rx_data
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one full-duplex WIDTH-bit transfer per accepted request.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN selects LSB-first shifting in both directions.
module spi_master #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  cmd,
  output logic         sck,
  output logic         ss_n,
  output logic         mosi,
  input  logic         miso
);

  localparam int unsigned CW       = $clog2(WIDTH + 1);
  localparam logic [7:0]  DIV_M1   = 8'(DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_e;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] w);
    return w >> 1;
  endfunction

  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] w, input logic b);
    return {b, w[WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] w);
    return w << 1;
  endfunction

  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] w, input logic b);
    return {w[WIDTH-2:0], b};
  endfunction
`endif

  state_e           state_q;
  logic [7:0]       hp_cnt_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] tx_sr_q;
  logic [WIDTH-1:0] rx_sr_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             sck_q;
  logic             ss_n_q;
  logic             mosi_q;

  // Transfer sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hp_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      sck_q       <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd.req_valid) begin
            tx_sr_q     <= cmd.tx_data;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            hp_cnt_q    <= DIV_M1;
            ss_n_q      <= 1'b0;
            mosi_q      <= first_bit(cmd.tx_data);
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end

        SETUP, LOW: begin
          if (hp_cnt_q == 8'd0) begin
            sck_q    <= 1'b1;
            hp_cnt_q <= DIV_M1;
            state_q  <= HIGH;
          end else begin
            hp_cnt_q <= hp_cnt_q - 8'd1;
          end
        end

        // Falling sck edge: capture miso, then either present the next bit or finish.
        HIGH: begin
          if (hp_cnt_q == 8'd0) begin
            sck_q     <= 1'b0;
            hp_cnt_q  <= DIV_M1;
            rx_sr_q   <= rx_shift(rx_sr_q, miso);
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= HOLD;
            end else begin
              tx_sr_q <= tx_shift(tx_sr_q);
              mosi_q  <= first_bit(tx_shift(tx_sr_q));
              state_q <= LOW;
            end
          end else begin
            hp_cnt_q <= hp_cnt_q - 8'd1;
          end
        end

        HOLD: begin
          if (hp_cnt_q == 8'd0) begin
            hp_cnt_q    <= DIV_M1;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rx_data_q   <= rx_sr_q;
            state_q     <= DONE;
          end else begin
            hp_cnt_q <= hp_cnt_q - 8'd1;
          end
        end

        DONE: begin
          hp_cnt_q    <= DIV_M1;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          sck_q       <= 1'b0;
          ss_n_q      <= 1'b1;
          mosi_q      <= 1'b1;
        end
      endcase
    end
  end

  assign cmd.req_ready = req_ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rx_data   = rx_data_q;
  assign sck           = sck_q;
  assign ss_n          = ss_n_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: DIV=2 instance for loopback/tied/handshake/reset cases,
// DIV=1 instance driving a bit-reversal target model.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;

  logic sck0, ss_n0, mosi0, miso0;
  logic sck1, ss_n1, mosi1, miso1;
  logic loop0;
  logic miso0_drv;

  int n_assert = 0;
  int n_fail   = 0;

  spi_master_if #(.WIDTH(16)) if0 ();
  spi_master_if #(.WIDTH(16)) if1 ();

  spi_master #(.WIDTH(16), .DIV(2)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (if0),
    .sck   (sck0),
    .ss_n  (ss_n0),
    .mosi  (mosi0),
    .miso  (miso0)
  );

  spi_master #(.WIDTH(16), .DIV(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (if1),
    .sck   (sck1),
    .ss_n  (ss_n1),
    .mosi  (mosi1),
    .miso  (miso1)
  );

  always #5 clk = ~clk;

  assign miso0 = loop0 ? mosi0 : miso0_drv;

  // Bit-reversal target: takes 8 bits in, then returns them reversed, MSB-first.
  logic [7:0] tgt_sr;
  int         tgt_cnt;
  logic       tgt_miso;

  always @(posedge sck1 or posedge ss_n1) begin
    if (ss_n1) begin
      tgt_cnt = 0;
    end else begin
      if (tgt_cnt < 8) tgt_sr = {tgt_sr[6:0], mosi1};
      tgt_cnt = tgt_cnt + 1;
    end
  end

  always @(negedge sck1 or posedge ss_n1) begin
    if (ss_n1) tgt_miso = 1'b0;
    else if (tgt_cnt >= 8 && tgt_cnt < 16) tgt_miso = tgt_sr[3'(tgt_cnt - 8)];
  end

  assign miso1 = tgt_miso;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer on instance 0; t=0 is the first falling clk after the accept edge.
  task automatic xfer0(input logic [15:0] tx, output logic [15:0] rx, output int lat,
                       output int rises, output logic [15:0] mbits, output int ssn_low,
                       output logic rsp_after, output logic rdy_after);
    logic prev_sck;
    lat = -1; rises = 0; mbits = '0; ssn_low = 0; rx = '0; prev_sck = 1'b0;
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.tx_data   = tx;
    @(negedge clk);
    if0.req_valid = 1'b0;
    if0.tx_data   = ~tx;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) @(negedge clk);
      if (sck0 && !prev_sck) begin
        rises++;
        mbits = {mbits[14:0], mosi0};
      end
      prev_sck = sck0;
      if (!ss_n0) ssn_low++;
      if (if0.rsp_valid) begin
        lat = t;
        rx  = if0.rx_data;
        break;
      end
    end
    @(negedge clk);
    rsp_after = if0.rsp_valid;
    rdy_after = if0.req_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    logic [15:0] mbits;
    logic        rsp_after, rdy_after;
    int          lat, rises, ssn_low;
    logic [15:0] expq[$];
    logic [15:0] exp_rx;
    int          acc, cmp, n_rsp;
    logic        ready_chk;

    rst_n = 1'b0;
    if0.req_valid = 1'b0; if0.tx_data = '0;
    if1.req_valid = 1'b0; if1.tx_data = '0;
    loop0 = 1'b0; miso0_drv = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_ss_n", 32'(ss_n0), 32'd1);
    check("rst_mosi", 32'(mosi0), 32'd1);
    check("rst_req_ready", 32'(if0.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("rst_rx_data", 32'(if0.rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback A53C, DIV=2
    loop0 = 1'b1;
    xfer0(16'hA53C, rx, lat, rises, mbits, ssn_low, rsp_after, rdy_after);
    check("loop_rx", 32'(rx), 32'h0000_A53C);
    check("loop_latency", 32'(lat), 32'd66);
    check("loop_sck_rises", 32'(rises), 32'd16);
    check("loop_mosi_bits", 32'(mbits), 32'h0000_A53C);
    check("loop_ss_n_low", 32'(ssn_low), 32'd66);
    check("loop_rsp_one_cycle", 32'(rsp_after), 32'd0);
    check("loop_ready_return", 32'(rdy_after), 32'd1);

    // Reset while idle clears the held response word
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("idle_rst_rx_data", 32'(if0.rx_data), 32'd0);
    check("idle_rst_ss_n", 32'(ss_n0), 32'd1);
    check("idle_rst_mosi", 32'(mosi0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // miso tied low, then high
    loop0 = 1'b0; miso0_drv = 1'b0;
    xfer0(16'h1234, rx, lat, rises, mbits, ssn_low, rsp_after, rdy_after);
    check("tied0_rx", 32'(rx), 32'h0000_0000);
    check("tied0_mosi_bits", 32'(mbits), 32'h0000_1234);
    miso0_drv = 1'b1;
    xfer0(16'h1234, rx, lat, rises, mbits, ssn_low, rsp_after, rdy_after);
    check("tied1_rx", 32'(rx), 32'h0000_FFFF);
    check("tied1_latency", 32'(lat), 32'd66);

    // Bit-reversal target on the DIV=1 instance
    @(negedge clk);
    if1.req_valid = 1'b1;
    if1.tx_data   = 16'hB100;
    @(negedge clk);
    if1.req_valid = 1'b0;
    if1.tx_data   = 16'h0000;
    lat = -1; rx = '0;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) @(negedge clk);
      if (if1.rsp_valid) begin
        lat = t;
        rx  = if1.rx_data;
        break;
      end
    end
    check("rev_rx", 32'(rx), 32'h0000_008D);
    check("rev_latency", 32'(lat), 32'd33);

    // req_valid held high, tx_data changing every cycle
    loop0 = 1'b1;
    acc = 0; cmp = 0; ready_chk = 1'b0;
    @(negedge clk);
    if0.req_valid = 1'b1;
    for (int t = 0; t < 600; t++) begin
      if (t > 0) @(negedge clk);
      if (ready_chk) begin
        check("b2b_ready_ret", 32'(if0.req_ready), 32'd1);
        ready_chk = 1'b0;
      end
      if (if0.rsp_valid) begin
        exp_rx = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        check("b2b_rx", 32'(if0.rx_data), 32'(exp_rx));
        cmp++;
        ready_chk = 1'b1;
      end
      if (cmp == 3) begin
        if0.req_valid = 1'b0;
        break;
      end
      if0.tx_data = 16'(t * 947 + 16'h0F0F);
      if (if0.req_ready) begin
        expq.push_back(if0.tx_data);
        acc++;
      end
    end
    @(negedge clk);
    check("b2b_ready_last", 32'(if0.req_ready), 32'd1);
    check("b2b_completions", 32'(cmp), 32'd3);
    check("b2b_accepts", 32'(acc), 32'd3);

    // Reset mid-transfer
    repeat (2) @(negedge clk);
    if0.req_valid = 1'b1;
    if0.tx_data   = 16'h5AC3;
    @(negedge clk);
    if0.req_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_ss_n_active", 32'(ss_n0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", 32'(ss_n0), 32'd1);
    check("mid_rst_sck", 32'(sck0), 32'd0);
    check("mid_rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(if0.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    repeat (100) begin
      @(negedge clk);
      if (if0.rsp_valid) n_rsp++;
    end
    check("mid_no_rsp", 32'(n_rsp), 32'd0);
    xfer0(16'hC35A, rx, lat, rises, mbits, ssn_low, rsp_after, rdy_after);
    check("post_rst_rx", 32'(rx), 32'h0000_C35A);
    check("post_rst_latency", 32'(lat), 32'd66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
